asc_frame_assembler: RTL and testbench
======================================

// Module: asc_frame_assembler
// PURPOSE
//  Sits between the UART protocol handler's ASC byte stream and the scan-chain
//  shifter inside the ASC path. Collects FRAME_BYTES bytes into one
//  {payload, addr} scan frame and hands the frame to the shifter over
//  valid/ready. Waits for the shifter's done pulse, then returns one status
//  byte to the handler. Drops stalled partial frames after a timeout.
// PARAMETERS
//  ADDR_BITS     12          scan address width
//  PAYLOAD_BITS  160         scan payload width
//  TIMEOUT_CLKS  1_000_000   max clk cycles between bytes of one frame (10 ms @100 MHz)
//  (local) FRAME_BYTES = ceil((ADDR_BITS+PAYLOAD_BITS)/8) = 22
// PORTS
//  clk               in   1             system clock (100 MHz)
//  reset             in   1             synchronous, active-high
//  data_valid        in   1             byte from UART handler valid
//  data_ready        out  1             assembler accepts byte
//  data_in           in   8             byte from UART handler
//  frame_valid       out  1             assembled frame offered to shifter
//  frame_ready       in   1             shifter accepts frame
//  frame_addr        out  ADDR_BITS     scan address
//  frame_payload     out  PAYLOAD_BITS  scan payload
//  shift_done        in   1             1-cycle pulse: shifter finished frame
//  response_valid    out  1             status byte valid
//  response_ready    in   1             UART handler accepts status byte
//  response_data     out  8             0x01 = ACK, 0xE1 = timeout error
//  busy              out  1             high in any state except COLLECT with byte_cnt==0
//  debug_byte_count  out  5             bytes collected in current frame
// BEHAVIOUR
//  - Clock and reset: one clock, clk. reset is synchronous and active-high.
//  - Reset: state=COLLECT, byte_cnt=0, timer=0, shift register cleared.
//    All outputs are 0 except data_ready=1.
//  - Byte order: the first byte received fills frame bits [7:0].
//    Byte k fills bits [8k+7:8k].
//    frame_addr = frame[ADDR_BITS-1:0].
//    frame_payload = frame[ADDR_BITS+PAYLOAD_BITS-1:ADDR_BITS].
//    Top pad bits (4 at defaults) are ignored.
//  - FSM states: COLLECT -> ISSUE -> WAIT_DONE -> RESPOND -> COLLECT.
//  - COLLECT:
//    - data_ready=1; a byte is accepted on data_valid&data_ready.
//    - Each accepted byte writes its slot, increments byte_cnt and clears timer.
//    - On the byte that makes byte_cnt==FRAME_BYTES: go to ISSUE next cycle and
//      reset byte_cnt to 0.
//    - While byte_cnt>0 and no byte arrives, timer increments.
//    - When timer reaches TIMEOUT_CLKS-1: discard the frame, byte_cnt=0,
//      load response 0xE1, go to RESPOND.
//    - timer does not run while byte_cnt==0.
//  - ISSUE:
//    - data_ready=0; frame_valid=1.
//    - frame_addr and frame_payload stay stable until handshake.
//    - On frame_valid&frame_ready: frame_valid drops next cycle; go to WAIT_DONE.
//  - WAIT_DONE:
//    - data_ready=0.
//    - On shift_done: load 0xE1->no, load 0x01 (ACK); go to RESPOND.
//    - There is no timeout here; the shifter is trusted.
//  - RESPOND:
//    - response_valid=1; response_data is held until response_valid&response_ready.
//    - After the handshake: go to COLLECT, data_ready=1 the following cycle.
//  - Latency:
//    - frame_valid rises 1 cycle after the last byte is accepted.
//    - response_valid rises 1 cycle after shift_done.
//  - Ignored inputs:
//    - shift_done is ignored outside WAIT_DONE.
//    - data_valid is ignored when data_ready=0; bytes are never dropped silently
//      because the handler is backpressured.
//  - Simultaneous events: a byte accepted in the same cycle the timer would
//    expire counts as arrival, so no timeout occurs.
//  - Reset in any state: abort immediately, no response emitted, partial frame lost.
//  - byte_cnt is 5 bits and is never allowed to exceed FRAME_BYTES.
//    debug_byte_count = byte_cnt.
// TESTING
//  1. Send bytes 0x00..0x15 back-to-back.
//     -> frame_valid 1 cycle after the last byte.
//     -> frame_addr=12'h100, frame_payload[11:0]=12'h020.
//     -> Pulse shift_done -> response 0x01.
//  2. Hold frame_ready=0 for 50 cycles in ISSUE.
//     -> frame_valid and frame fields stable; data_ready=0 throughout.
//  3. Send 10 bytes, then idle with TIMEOUT_CLKS=100.
//     -> response 0xE1 after 100 idle cycles; byte_cnt=0.
//     -> The next 22 bytes form a clean frame.
//  4. Byte arrives exactly on the expiry cycle -> no timeout; collection continues.
//  5. Hold response_ready=0 for 20 cycles -> response_valid and 0x01 held;
//     data_ready=0 until the handshake.
//  6. Assert reset mid-COLLECT (byte 7) and in WAIT_DONE.
//     -> Outputs at reset values next cycle; no response byte emitted.
```

Note: the WAIT_DONE bullet contains an editing slip ("load 0xE1->no, load 0x01 (ACK)"). The intended behaviour is: on shift_done, load 0x01 (ACK).

Source files
------------

// File: rtl/asc_frame_assembler.sv
// Assembles UART byte stream into one {payload, addr} scan frame, hands it to the
// scan shifter over valid/ready and returns a single status byte (ACK or timeout).
//
// state     | meaning
// ----------+----------------------------------------------------------
// COLLECT   | accepting bytes; idle timer runs once a frame has started
// ISSUE     | frame offered to shifter, held until frame_ready
// WAIT_DONE | shifter busy, waiting for shift_done pulse
// RESPOND   | status byte offered to UART handler, held until response_ready
module asc_frame_assembler #(
    parameter int ADDR_BITS    = 12,
    parameter int PAYLOAD_BITS = 160,
    parameter int TIMEOUT_CLKS = 1_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    data_valid,
    output logic                    data_ready,
    input  logic [7:0]              data_in,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic [ADDR_BITS-1:0]    frame_addr,
    output logic [PAYLOAD_BITS-1:0] frame_payload,
    input  logic                    shift_done,
    output logic                    response_valid,
    input  logic                    response_ready,
    output logic [7:0]              response_data,
    output logic                    busy,
    output logic [4:0]              debug_byte_count
);

    localparam int FRAME_BITS  = ADDR_BITS + PAYLOAD_BITS;
    localparam int FRAME_BYTES = (FRAME_BITS + 7) / 8;
    localparam int TMR_W       = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CLKS - 1);
    localparam logic [4:0]       CNT_LAST = 5'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        COLLECT,
        ISSUE,
        WAIT_DONE,
        RESPOND
    } state_t;

    state_t                state_q, state_d;
    logic [4:0]            byte_cnt;
    logic [TMR_W-1:0]      timer;
    logic [FRAME_BITS-1:0] frame_q;
    logic [FRAME_BITS-1:0] slot_mask;
    logic [FRAME_BITS-1:0] slot_data;
    logic [7:0]            resp_q;
    logic                  byte_take;
    logic                  timeout_hit;
    logic                  ack_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        data_ready     = 1'b0;
        frame_valid    = 1'b0;
        response_valid = 1'b0;
        byte_take      = 1'b0;
        timeout_hit    = 1'b0;
        ack_load       = 1'b0;
        case (state_q)
            COLLECT: begin
                data_ready = 1'b1;
                // an arriving byte always wins over a simultaneous expiry
                if (data_valid) begin
                    byte_take = 1'b1;
                    if (byte_cnt == CNT_LAST) begin
                        state_d = ISSUE;
                    end
                end else if (byte_cnt != 5'd0 && timer == TMR_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = RESPOND;
                end
            end
            ISSUE: begin
                frame_valid = 1'b1;
                if (frame_ready) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (shift_done) begin
                    ack_load = 1'b1;
                    state_d  = RESPOND;
                end
            end
            RESPOND: begin
                response_valid = 1'b1;
                if (response_ready) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // Shifting within the frame width drops the pad bits of the last byte.
    assign slot_mask = FRAME_BITS'(8'hFF) << {byte_cnt, 3'b000};
    assign slot_data = FRAME_BITS'(data_in) << {byte_cnt, 3'b000};

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt <= 5'd0;
            timer    <= '0;
            frame_q  <= '0;
            resp_q   <= 8'h00;
        end else begin
            if (byte_take) begin
                frame_q  <= (frame_q & ~slot_mask) | slot_data;
                byte_cnt <= (byte_cnt == CNT_LAST) ? 5'd0 : byte_cnt + 5'd1;
                timer    <= '0;
            end else if (timeout_hit) begin
                frame_q  <= '0;
                byte_cnt <= 5'd0;
                timer    <= '0;
                resp_q   <= 8'hE1;
            end else if (state_q == COLLECT && byte_cnt != 5'd0) begin
                timer <= timer + TMR_W'(1);
            end
            if (ack_load) begin
                resp_q <= 8'h01;
            end
        end
    end

    assign frame_addr       = frame_q[ADDR_BITS-1:0];
    assign frame_payload    = frame_q[FRAME_BITS-1:ADDR_BITS];
    assign response_data    = resp_q;
    assign busy             = !(state_q == COLLECT && byte_cnt == 5'd0);
    assign debug_byte_count = byte_cnt;

endmodule

// File: tb/tb_asc_frame_assembler.sv
// Bench for asc_frame_assembler: directed scenarios plus random traffic, checked
// every cycle against a queue-based transaction model.
module tb_asc_frame_assembler;

    localparam int AB  = 12;
    localparam int PB  = 160;
    localparam int TMO = 100;
    localparam int NB  = 22;
    localparam int FB  = AB + PB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          data_valid = 1'b0;
    logic [7:0]    data_in = 8'h00;
    logic          frame_ready = 1'b0;
    logic          shift_done = 1'b0;
    logic          response_ready = 1'b0;
    logic          data_ready, frame_valid, response_valid, busy;
    logic [AB-1:0] frame_addr;
    logic [PB-1:0] frame_payload;
    logic [7:0]    response_data;
    logic [4:0]    debug_byte_count;

    asc_frame_assembler #(
        .ADDR_BITS(AB), .PAYLOAD_BITS(PB), .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .frame_addr(frame_addr), .frame_payload(frame_payload),
        .shift_done(shift_done),
        .response_valid(response_valid), .response_ready(response_ready),
        .response_data(response_data),
        .busy(busy), .debug_byte_count(debug_byte_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // transaction model
    logic [7:0]    m_coll[$];
    int            m_idle = 0;
    bit            m_offer = 1'b0;
    logic [FB-1:0] m_frame = '0;
    bit            m_wait = 1'b0;
    logic [7:0]    m_resp[$];

    // outputs sampled at the most recent negedge
    logic          s_dr, s_fv, s_rv, s_busy;
    logic [4:0]    s_cnt;
    logic [AB-1:0] s_addr;
    logic [PB-1:0] s_pay;
    logic [7:0]    s_rd;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit m_accepting();
        return !m_offer && !m_wait && m_resp.size() == 0;
    endfunction

    task automatic model_step();
        if (reset) begin
            m_coll.delete();
            m_resp.delete();
            m_idle  = 0;
            m_offer = 1'b0;
            m_wait  = 1'b0;
        end else if (m_accepting()) begin
            if (data_valid) begin
                m_coll.push_back(data_in);
                m_idle = 0;
                if (m_coll.size() == NB) begin
                    m_frame = '0;
                    foreach (m_coll[k]) m_frame = m_frame | (FB'(m_coll[k]) << (8 * k));
                    m_offer = 1'b1;
                    m_coll.delete();
                end
            end else if (m_coll.size() > 0) begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_coll.delete();
                    m_idle = 0;
                    m_resp.push_back(8'hE1);
                end
            end
        end else if (m_offer) begin
            if (frame_ready) begin
                m_offer = 1'b0;
                m_wait  = 1'b1;
            end
        end else if (m_wait) begin
            if (shift_done) begin
                m_wait = 1'b0;
                m_resp.push_back(8'h01);
            end
        end else if (response_ready) begin
            void'(m_resp.pop_front());
        end
    endtask

    // One clock: compare at negedge, advance model at posedge, release inputs #1 later.
    task automatic cycle();
        @(negedge clk);
        s_dr = data_ready; s_fv = frame_valid; s_rv = response_valid; s_busy = busy;
        s_cnt = debug_byte_count; s_addr = frame_addr; s_pay = frame_payload; s_rd = response_data;
        chk("data_ready", s_dr, m_accepting());
        chk("frame_valid", s_fv, m_offer);
        chk("response_valid", s_rv, m_resp.size() != 0);
        chk("busy", s_busy, !(m_accepting() && m_coll.size() == 0));
        chk("byte_count", s_cnt, m_coll.size());
        if (m_offer) begin
            chk("frame_addr", s_addr, m_frame[AB-1:0]);
            chk("frame_payload", s_pay, m_frame[FB-1:AB]);
        end
        if (m_resp.size() != 0) chk("response_data", s_rd, m_resp[0]);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        data_valid = 1'b1;
        data_in    = b;
        cycle();
        data_valid = 1'b0;
    endtask

    task automatic complete_frame();
        frame_ready = 1'b1;
        cycle();
        frame_ready = 1'b0;
        shift_done  = 1'b1;
        cycle();
        shift_done     = 1'b0;
        response_ready = 1'b1;
        cycle();
        response_ready = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // reset values
        cycle();
        cycle();
        chk("rst data_ready", s_dr, 1'b1);
        chk("rst frame_valid", s_fv, 1'b0);
        chk("rst response_valid", s_rv, 1'b0);
        chk("rst busy", s_busy, 1'b0);
        chk("rst byte_count", s_cnt, 5'd0);
        chk("rst frame_addr", s_addr, 12'h000);
        chk("rst frame_payload", s_pay, 160'h0);
        chk("rst response_data", s_rd, 8'h00);
        reset = 1'b0;
        cycle();

        // bytes 0x00..0x15, then hold frame_ready low for 50 cycles
        for (int i = 0; i < NB; i++) send_byte(8'(i));
        chk("fv before last byte edge", s_fv, 1'b0);
        for (int i = 0; i < 50; i++) begin
            cycle();
            chk("issue frame_valid", s_fv, 1'b1);
            chk("issue data_ready", s_dr, 1'b0);
            chk("issue addr literal", s_addr, 12'h100);
            chk("issue payload lsb literal", s_pay[11:0], 12'h020);
        end
        frame_ready = 1'b1;
        cycle();
        frame_ready = 1'b0;
        cycle();
        chk("fv drop after handshake", s_fv, 1'b0);
        repeat (3) cycle();
        shift_done = 1'b1;
        cycle();
        shift_done = 1'b0;
        cycle();
        chk("rv one cycle after done", s_rv, 1'b1);
        chk("ack literal", s_rd, 8'h01);
        // response held for 20 cycles
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("held rv", s_rv, 1'b1);
            chk("held ack", s_rd, 8'h01);
            chk("held data_ready", s_dr, 1'b0);
        end
        response_ready = 1'b1;
        cycle();
        response_ready = 1'b0;
        cycle();
        chk("rv after resp handshake", s_rv, 1'b0);
        chk("dr after resp handshake", s_dr, 1'b1);

        // timeout after 10 bytes
        for (int i = 0; i < 10; i++) send_byte(8'($urandom));
        n = 0;
        cycle();
        while (!s_rv && n < 300) begin
            n++;
            cycle();
        end
        chk("timeout idle cycles", n, TMO);
        chk("timeout code literal", s_rd, 8'hE1);
        chk("timeout byte_count", s_cnt, 5'd0);
        response_ready = 1'b1;
        cycle();
        response_ready = 1'b0;
        for (int i = 0; i < NB; i++) send_byte(8'($urandom));
        cycle();
        chk("clean frame after timeout", s_fv, 1'b1);
        complete_frame();

        // byte on the expiry cycle counts as arrival
        for (int i = 0; i < 5; i++) send_byte(8'($urandom));
        repeat (TMO - 1) cycle();
        send_byte(8'hA5);
        cycle();
        chk("expiry-cycle byte no rv", s_rv, 1'b0);
        chk("expiry-cycle byte count", s_cnt, 5'd6);
        for (int i = 0; i < NB - 6; i++) send_byte(8'($urandom));
        cycle();
        chk("frame after near-expiry", s_fv, 1'b1);
        complete_frame();

        // reset during collect (7 bytes in) and during WAIT_DONE
        for (int i = 0; i < 7; i++) send_byte(8'($urandom));
        reset      = 1'b1;
        data_valid = 1'b1;
        cycle();
        reset      = 1'b0;
        data_valid = 1'b0;
        cycle();
        chk("mid-collect reset count", s_cnt, 5'd0);
        chk("mid-collect reset busy", s_busy, 1'b0);
        chk("mid-collect reset dr", s_dr, 1'b1);
        for (int i = 0; i < NB; i++) send_byte(8'($urandom));
        frame_ready = 1'b1;
        cycle();
        frame_ready = 1'b0;
        cycle();
        reset      = 1'b1;
        shift_done = 1'b1;
        cycle();
        reset      = 1'b0;
        shift_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("wait-reset no response", s_rv, 1'b0);
            chk("wait-reset data_ready", s_dr, 1'b1);
        end

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            data_valid     = ($urandom_range(0, 9) < 7);
            data_in        = 8'($urandom);
            frame_ready    = 1'($urandom);
            shift_done     = ($urandom_range(0, 9) < 2);
            response_ready = 1'($urandom);
            reset          = ($urandom_range(0, 999) == 0);
            cycle();
            reset = 1'b0;
            if ($urandom_range(0, 299) == 0) begin
                data_valid = 1'b0;
                repeat ($urandom_range(TMO - 5, TMO + 1)) cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
